dcache_mshr: RTL

- Miss-status holding register file sitting between the data cache and the memory bus.
- Accepts block misses from the load/store unit and issues MEM_LOAD requests to memory.
- Matches tagged memory responses back to their entries.
- Drives the block-fill interface into the dcache: write enable, 64-bit block, and the original access info so the cache can merge a pending store.

---
 rtl/dcache_mshr.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dcache_mshr.sv
// Miss-status holding registers between the data cache and the memory bus.
// Latency: a miss issues MEM_LOAD the cycle after acceptance and fills the cycle after its response.
// Backpressure: miss_ready drops when full or the block is already outstanding; fills wait on fill_grant.
// Optional macro DCACHE_MSHR_FILL_BYPASS_EN: a response with no READY entry and fill_grant fills the same cycle.
module dcache_mshr #(
  parameter int NUM_MSHR     = 4,
  parameter int MEM_TAG_BITS = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          miss_valid,
  input  logic [31:0]                   miss_addr,
  input  logic                          miss_is_store,
  input  logic [1:0]                    miss_st_size,
  input  logic [31:0]                   miss_st_data,
  output logic                          miss_ready,
  output logic [1:0]                    proc2mem_command,
  output logic [31:0]                   proc2mem_addr,
  input  logic [MEM_TAG_BITS-1:0]       mem2proc_transaction_tag,
  input  logic [63:0]                   mem2proc_data,
  input  logic [MEM_TAG_BITS-1:0]       mem2proc_data_tag,
  input  logic                          fill_grant,
  output logic                          mshr2Dcache_wr,
  output logic [63:0]                   mshr2Dcache_mem_block,
  output logic [31:0]                   mshr2Dcache_addr,
  output logic                          mshr2Dcache_is_store,
  output logic [1:0]                    mshr2Dcache_st_size,
  output logic [31:0]                   mshr2Dcache_st_data,
  output logic                          mshr_full,
  output logic [$clog2(NUM_MSHR):0]     mshr_count
);

  localparam int IDX_W = $clog2(NUM_MSHR);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_LOAD = 2'd1;

  typedef enum logic [1:0] {INVALID, PENDING, WAIT, READY} entry_state_t;

  entry_state_t            state_q  [NUM_MSHR];
  entry_state_t            state_d  [NUM_MSHR];
  logic [31:0]             addr_q   [NUM_MSHR];
  logic                    store_q  [NUM_MSHR];
  logic [1:0]              size_q   [NUM_MSHR];
  logic [31:0]             sdata_q  [NUM_MSHR];
  logic [MEM_TAG_BITS-1:0] tag_q    [NUM_MSHR];
  logic [63:0]             block_q  [NUM_MSHR];

  logic             alloc_any, dup_hit, issue_any, fill_any, rsp_hit;
  logic [IDX_W-1:0] alloc_idx, issue_idx, fill_idx, rsp_idx;
  logic [CNT_W-1:0] count;
  logic             alloc_fire, issue_fire, fill_fire, bypass_fire;

  // Scan entries (high to low so the lowest index wins) for free, pending, ready and response-matching slots.
  always_comb begin
    alloc_any = 1'b0;
    alloc_idx = '0;
    dup_hit   = 1'b0;
    issue_any = 1'b0;
    issue_idx = '0;
    fill_any  = 1'b0;
    fill_idx  = '0;
    rsp_hit   = 1'b0;
    rsp_idx   = '0;
    count     = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_q[i] == INVALID) begin
        alloc_any = 1'b1;
        alloc_idx = IDX_W'(i);
      end else begin
        count = count + CNT_W'(1);
        if (addr_q[i][31:3] == miss_addr[31:3]) dup_hit = 1'b1;
      end
      if (state_q[i] == PENDING) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (state_q[i] == READY) begin
        fill_any = 1'b1;
        fill_idx = IDX_W'(i);
      end
      if (state_q[i] == WAIT && mem2proc_data_tag != '0 && tag_q[i] == mem2proc_data_tag) begin
        rsp_hit = 1'b1;
        rsp_idx = IDX_W'(i);
      end
    end
  end

`ifdef DCACHE_MSHR_FILL_BYPASS_EN
  assign bypass_fire = !fill_any && fill_grant && rsp_hit;
`else
  assign bypass_fire = 1'b0;
`endif

  assign miss_ready  = alloc_any && !dup_hit;
  assign alloc_fire  = miss_valid && miss_ready;
  assign issue_fire  = issue_any && (mem2proc_transaction_tag != '0);
  assign fill_fire   = fill_any && fill_grant;
  assign mshr_full   = !alloc_any;
  assign mshr_count  = count;

  assign proc2mem_command = issue_any ? MEM_LOAD : MEM_NONE;
  assign proc2mem_addr    = issue_any ? {addr_q[issue_idx][31:3], 3'b000} : 32'd0;

  // Fill port: the lowest READY entry, else a same-cycle bypassed response, else all zero.
  always_comb begin
    mshr2Dcache_wr        = 1'b0;
    mshr2Dcache_mem_block = '0;
    mshr2Dcache_addr      = '0;
    mshr2Dcache_is_store  = 1'b0;
    mshr2Dcache_st_size   = '0;
    mshr2Dcache_st_data   = '0;
    if (fill_any) begin
      mshr2Dcache_wr        = fill_grant;
      mshr2Dcache_mem_block = block_q[fill_idx];
      mshr2Dcache_addr      = addr_q[fill_idx];
      mshr2Dcache_is_store  = store_q[fill_idx];
      mshr2Dcache_st_size   = size_q[fill_idx];
      mshr2Dcache_st_data   = sdata_q[fill_idx];
    end else if (bypass_fire) begin
      mshr2Dcache_wr        = 1'b1;
      mshr2Dcache_mem_block = mem2proc_data;
      mshr2Dcache_addr      = addr_q[rsp_idx];
      mshr2Dcache_is_store  = store_q[rsp_idx];
      mshr2Dcache_st_size   = size_q[rsp_idx];
      mshr2Dcache_st_data   = sdata_q[rsp_idx];
    end
  end

  // Entry state transitions; each event targets a different state so they never collide on one entry.
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) state_d[i] = state_q[i];
    if (alloc_fire) state_d[alloc_idx] = PENDING;
    if (issue_fire) state_d[issue_idx] = WAIT;
    if (rsp_hit)    state_d[rsp_idx]   = bypass_fire ? INVALID : READY;
    if (fill_fire)  state_d[fill_idx]  = INVALID;
  end

  // State register plus per-entry field capture on allocate, issue and response.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= INVALID;
        addr_q[i]  <= '0;
        store_q[i] <= 1'b0;
        size_q[i]  <= '0;
        sdata_q[i] <= '0;
        tag_q[i]   <= '0;
        block_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= state_d[i];
        if (alloc_fire && alloc_idx == IDX_W'(i)) begin
          addr_q[i]  <= miss_addr;
          store_q[i] <= miss_is_store;
          size_q[i]  <= miss_st_size;
          sdata_q[i] <= miss_st_data;
        end
        if (issue_fire && issue_idx == IDX_W'(i)) tag_q[i] <= mem2proc_transaction_tag;
        if (rsp_hit && rsp_idx == IDX_W'(i)) block_q[i] <= mem2proc_data;
      end
    end
  end

endmodule
